rmii_tx_framer: RTL and testbench
=================================

// Module: rmii_tx_framer
// PURPOSE
// Transmit-side counterpart of the RMII receive deserialiser in the Ethernet framing block. Accepts a
// byte stream (AXI-stream style) from the TX packet buffer and emits preamble, SFD, payload, pad,
// CRC-32 FCS and inter-frame gap as RMII dibits at 100 Mb/s (one byte per 4 clk_rmii cycles).
// Replaces the external GMII TX core plus the inline gmii_txd-to-dibit shifter.
// PARAMETERS
// MIN_FRAME_LENGTH 64  minimum frame bytes incl. FCS, excl. preamble/SFD; payload padded to this-4
// ENABLE_PADDING   1   1: pad short payloads with 0x00; 0: no padding
// IFG_BYTES        12  inter-frame gap in byte times (tx_en low)
// PORTS
// clk_rmii   in   1   50 MHz RMII reference clock
// rstn       in   1   synchronous, active-low reset
// s_tdata    in   8   payload byte
// s_tvalid   in   1   payload byte valid; in IDLE also requests a new frame
// s_tlast    in   1   marks final payload byte
// s_tready   out  1   byte accepted this cycle when s_tvalid&s_tready
// txd        out  2   RMII transmit dibit, registered
// tx_en      out  1   RMII transmit enable, registered
// busy       out  1   high from frame start until end of IFG
// tx_done    out  1   one-cycle pulse after last FCS dibit of a good frame
// underrun   out  1   sticky: s_tvalid low when a payload byte was required; cleared at next frame start
// fcs        out  32  FCS value (~crc) of the last completed frame, byte0 = bits[7:0]
// BEHAVIOUR
// - Reset: state IDLE, txd=0, tx_en=0, s_tready=0, busy=0, tx_done=0, underrun=0, fcs=0, crc=FFFFFFFF.
//   Reset asserted mid-frame aborts immediately: tx_en low on the next edge, no FCS, no tx_done.
// - 2-bit phase counter ph (0..3) per byte slot; shift register loaded at ph==3 for the next slot.
//   Dibit order LSB first: byte[1:0], [3:2], [5:4], [7:6].
// - States: IDLE -> PRE (7 x 0x55) -> SFD (0xD5) -> DATA -> [PAD] -> FCS (4 bytes) -> IFG -> IDLE.
// - IDLE: when s_tvalid=1, next cycle tx_en=1, txd=01 (first preamble dibit), busy=1, underrun cleared.
//   s_tready is NOT asserted in IDLE; the first byte is consumed later in the SFD slot.
// - s_tready = (state==SFD | state==DATA & !last_taken) & ph==3; combinational from state/ph only,
//   never from s_tvalid. Exactly one byte consumed per slot.
// - DATA: byte consumed with s_tlast -> after that slot go PAD if ENABLE_PADDING and
//   byte_cnt < MIN_FRAME_LENGTH-4, else FCS. byte_cnt is 11 bits, saturates at 2047 (no truncation).
// - PAD: emit 0x00 until byte_cnt == MIN_FRAME_LENGTH-4, then FCS.
// - CRC: reflected CRC-32 (poly 04C11DB7), init FFFFFFFF, updated per byte over DATA+PAD bytes only.
//   FCS = ~crc, sent bits[7:0] first; fcs output updated when FCS state entered.
// - Underrun: s_tvalid=0 while s_tready=1 -> set underrun, tx_en low next cycle, go IFG, no tx_done,
//   fcs unchanged. Remaining input bytes belong to the aborted frame; upstream must flush them.
// - IFG: tx_en=0, txd=0 for IFG_BYTES*4 cycles; s_tvalid ignored; then IDLE, busy=0.
// - tx_done pulses on the cycle tx_en falls after a complete FCS.
// - tx_en high duration for a good frame = 4*(8 + max(payload,pad target) + 4) cycles.
// TESTING
// 1 ENABLE_PADDING=0, payload ASCII "123456789" -> 21 bytes on wire: 55x7, D5, 31..39, 26 39 F4 CB;
//   fcs=CBF43926; tx_en high 84 cycles; tx_done once.
// 2 Defaults, 9-byte payload -> 51 zero pad bytes, tx_en high 288 cycles, 4 FCS bytes follow byte 60.
// 3 Back-to-back 2 frames, s_tvalid held high -> tx_en low exactly 48 cycles between frames, busy low
//   for one cycle only.
// 4 Drop s_tvalid for byte 5 of a 100-byte frame -> underrun=1, tx_en low next cycle, no tx_done,
//   fcs unchanged; next frame start clears underrun.
// 5 rstn low for 1 cycle during DATA -> tx_en=0, s_tready=0, busy=0 next edge; fresh frame then correct.
// 6 Random s_tvalid stalls outside s_tready windows, lengths 1..1514 -> wire decoded by RMII receiver
//   model matches payload, FCS checks good, s_tready never asserted outside ph==3.

Source files
------------

// File: rtl/rmii_tx_framer.sv
// RMII transmit framer: byte stream in, preamble/SFD/payload/pad/FCS out as LSB-first dibits, then IFG.
// A byte slot lasts four clk_rmii cycles; the following slot's byte is loaded on the slot's last cycle.
module rmii_tx_framer #(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int ENABLE_PADDING   = 1,
  parameter int IFG_BYTES        = 12
) (
  input  logic        clk_rmii,
  input  logic        rstn,
  input  logic [7:0]  s_tdata,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  output logic        s_tready,
  output logic [1:0]  txd,
  output logic        tx_en,
  output logic        busy,
  output logic        tx_done,
  output logic        underrun,
  output logic [31:0] fcs
);
  localparam int IFG_CYC = IFG_BYTES * 4;
  localparam int IFG_W   = $clog2(IFG_CYC + 1);
  localparam logic [10:0]      PAD_TGT  = 11'(MIN_FRAME_LENGTH - 4);
  // The IDLE cycle before the next frame counts toward the gap, hence -2.
  localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYC - 2);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG} state_e;

  state_e           state_q, state_d;
  logic [1:0]       ph_q, txd_q;
  logic [7:0]       sr_q, ld_byte, fcs_nxt;
  logic [2:0]       slot_q;
  logic [10:0]      cnt_q;
  logic [31:0]      crc_q, fcs_q;
  logic [IFG_W-1:0] ifg_q;
  logic             last_q, tx_en_q, done_q, und_q;
  logic             slot_end, pad_need, start, take, ld, crc_en;

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign slot_end = (ph_q == 2'd3);
  assign pad_need = (ENABLE_PADDING != 0) && (cnt_q < PAD_TGT);
  assign start    = (state_q == S_IDLE) && s_tvalid;

  always_ff @(posedge clk_rmii) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (s_tvalid) state_d = S_PRE;
      S_PRE:  if (slot_end && slot_q == 3'd6) state_d = S_SFD;
      S_SFD:  if (slot_end) state_d = s_tvalid ? S_DATA : S_IFG;
      S_DATA: if (slot_end) begin
        if (!last_q)       state_d = s_tvalid ? S_DATA : S_IFG;
        else if (pad_need) state_d = S_PAD;
        else               state_d = S_FCS;
      end
      S_PAD:  if (slot_end && cnt_q == PAD_TGT) state_d = S_FCS;
      S_FCS:  if (slot_end && slot_q == 3'd3) state_d = S_IFG;
      S_IFG:  if (ifg_q == IFG_LAST) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_tready = slot_end && (state_q == S_SFD || (state_q == S_DATA && !last_q));
    take     = s_tready && s_tvalid;
    ld       = start || (state_q != S_IDLE && slot_end &&
                         (state_d inside {S_PRE, S_SFD, S_DATA, S_PAD, S_FCS}));
    case (slot_q[1:0])
      2'd0:    fcs_nxt = fcs_q[15:8];
      2'd1:    fcs_nxt = fcs_q[23:16];
      default: fcs_nxt = fcs_q[31:24];
    endcase
    case (state_d)
      S_PRE:   ld_byte = 8'h55;
      S_SFD:   ld_byte = 8'hD5;
      S_DATA:  ld_byte = s_tdata;
      S_FCS:   ld_byte = (state_q == S_FCS) ? fcs_nxt : ~crc_q[7:0];
      default: ld_byte = 8'h00;
    endcase
    crc_en = ld && (state_d == S_DATA || state_d == S_PAD);
  end

  always_ff @(posedge clk_rmii) begin
    if (!rstn) begin
      ph_q    <= 2'd0;
      sr_q    <= 8'h00;
      txd_q   <= 2'd0;
      tx_en_q <= 1'b0;
      slot_q  <= 3'd0;
      cnt_q   <= 11'd0;
      last_q  <= 1'b0;
      crc_q   <= 32'hFFFFFFFF;
      fcs_q   <= 32'h0;
      ifg_q   <= '0;
      done_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      done_q <= (state_q == S_FCS) && (state_d == S_IFG);
      ifg_q  <= (state_q == S_IFG) ? ifg_q + IFG_W'(1) : '0;
      if (ld) begin
        txd_q   <= ld_byte[1:0];
        sr_q    <= {2'b00, ld_byte[7:2]};
        ph_q    <= 2'd0;
        tx_en_q <= 1'b1;
        slot_q  <= (state_d == state_q) ? slot_q + 3'd1 : 3'd0;
      end else begin
        txd_q <= sr_q[1:0];
        sr_q  <= {2'b00, sr_q[7:2]};
        ph_q  <= ph_q + 2'd1;
      end
      if (state_d == S_IFG && state_q != S_IFG) begin
        tx_en_q <= 1'b0;
        txd_q   <= 2'd0;
        sr_q    <= 8'h00;
      end
      if (start) begin
        crc_q  <= 32'hFFFFFFFF;
        cnt_q  <= 11'd0;
        last_q <= 1'b0;
        und_q  <= 1'b0;
      end else begin
        if (crc_en) begin
          crc_q <= crc8(crc_q, ld_byte);
          if (cnt_q != 11'h7FF) cnt_q <= cnt_q + 11'd1;
        end
        if (take && s_tlast) last_q <= 1'b1;
        if (s_tready && !s_tvalid) und_q <= 1'b1;
      end
      if (state_d == S_FCS && state_q != S_FCS) fcs_q <= ~crc_q;
    end
  end

  assign txd      = txd_q;
  assign tx_en    = tx_en_q;
  assign busy     = (state_q != S_IDLE);
  assign tx_done  = done_q;
  assign underrun = und_q;
  assign fcs      = fcs_q;
endmodule

// File: tb/tb_rmii_tx_framer.sv
// Bench for rmii_tx_framer: decodes the RMII wire back to bytes and compares against frames built
// from payload + zero pad + reference CRC-32.
`timescale 1ns/1ps
module tb_rmii_tx_framer;
  typedef logic [7:0] bq_t[$];

  logic        clk_rmii = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, np_go = 1'b0;
  logic        s_tready, tx_en, busy, tx_done, underrun;
  logic [1:0]  txd;
  logic [31:0] fcs;
  logic        np_tready, np_tx_en, np_busy, np_tx_done, np_underrun;
  logic [1:0]  np_txd;
  logic [31:0] np_fcs;
  int checks = 0, errors = 0;

  always #10 clk_rmii = ~clk_rmii;

  rmii_tx_framer dut (
    .clk_rmii(clk_rmii), .rstn(rstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tready(s_tready), .txd(txd), .tx_en(tx_en), .busy(busy), .tx_done(tx_done),
    .underrun(underrun), .fcs(fcs));

  rmii_tx_framer #(.ENABLE_PADDING(0)) dut_np (
    .clk_rmii(clk_rmii), .rstn(rstn), .s_tdata(s_tdata), .s_tvalid(s_tvalid & np_go),
    .s_tlast(s_tlast), .s_tready(np_tready), .txd(np_txd), .tx_en(np_tx_en), .busy(np_busy),
    .tx_done(np_tx_done), .underrun(np_underrun), .fcs(np_fcs));

  // wire receiver for the padding instance
  bq_t rx_cur, rx_last;
  logic [7:0] rx_sh = 8'h00;
  int rx_nd = 0, rx_cyc = 0, rx_lcyc = 0, n_done = 0, done_bad = 0, tready_bad = 0;
  int low_run = 0, last_gap = 0, bl_run = 0, last_bgap = 0;
  bit prev_en = 1'b0, prev_busy = 1'b0;

  always @(negedge clk_rmii) begin
    logic [7:0] sh_n;
    sh_n = {txd, rx_sh[7:2]};
    if (s_tready === 1'b1 && !(tx_en === 1'b1 && rx_cyc % 4 == 3)) tready_bad <= tready_bad + 1;
    if (tx_done === 1'b1) begin
      n_done <= n_done + 1;
      if (!(prev_en && tx_en === 1'b0)) done_bad <= done_bad + 1;
    end
    if (tx_en === 1'b1) begin
      rx_sh <= sh_n;
      if (rx_nd == 3) begin rx_cur.push_back(sh_n); rx_nd <= 0; end
      else rx_nd <= rx_nd + 1;
      rx_cyc <= rx_cyc + 1;
      if (!prev_en) last_gap <= low_run;
      low_run <= 0;
    end else begin
      if (prev_en) begin rx_last = rx_cur; rx_lcyc <= rx_cyc; rx_cur.delete(); end
      rx_nd <= 0;
      rx_cyc <= 0;
      low_run <= low_run + 1;
    end
    if (busy === 1'b1) begin
      if (!prev_busy) last_bgap <= bl_run;
      bl_run <= 0;
    end else bl_run <= bl_run + 1;
    prev_en <= (tx_en === 1'b1);
    prev_busy <= (busy === 1'b1);
  end

  // wire receiver for the no-padding instance
  bq_t np_cur, np_last;
  logic [7:0] np_sh = 8'h00;
  int np_nd = 0, np_cyc = 0, np_lcyc = 0, np_done = 0;
  bit np_prev = 1'b0;

  always @(negedge clk_rmii) begin
    logic [7:0] nsh;
    nsh = {np_txd, np_sh[7:2]};
    if (np_tx_done === 1'b1) np_done <= np_done + 1;
    if (np_tx_en === 1'b1) begin
      np_sh <= nsh;
      if (np_nd == 3) begin np_cur.push_back(nsh); np_nd <= 0; end
      else np_nd <= np_nd + 1;
      np_cyc <= np_cyc + 1;
    end else begin
      if (np_prev) begin np_last = np_cur; np_lcyc <= np_cyc; np_cur.delete(); end
      np_nd <= 0;
      np_cyc <= 0;
    end
    np_prev <= (np_tx_en === 1'b1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_ref(input bq_t d);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c ^= {24'h0, d[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic bq_t rand_pay(input int n);
    bq_t p;
    for (int i = 0; i < n; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  // Feeds pay through the handshake; drop_at/rst_at abort at that byte's consume window.
  task automatic send(input bq_t pay, input bit stall, input int drop_at, input int rst_at);
    int idx = 0, guard = 0;
    bit acc;
    while (idx < pay.size() && guard < 20000) begin
      @(negedge clk_rmii);
      guard++;
      s_tdata = pay[idx];
      s_tlast = (idx == pay.size() - 1);
      if (s_tready === 1'b1 && idx == drop_at) begin
        s_tvalid = 1'b0;
        @(posedge clk_rmii); #1;
        chk("und_txen_low", tx_en, 0);
        chk("und_flag", underrun, 1);
        return;
      end
      if (s_tready === 1'b1 && idx == rst_at) begin
        rstn = 1'b0;
        s_tvalid = 1'b0;
        @(posedge clk_rmii); #1;
        chk("rst_txen", tx_en, 0);
        chk("rst_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk_rmii);
        rstn = 1'b1;
        return;
      end
      s_tvalid = (stall && s_tready !== 1'b1) ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = s_tvalid && (s_tready === 1'b1);
      @(posedge clk_rmii);
      if (acc) idx++;
    end
    chk("send_all_bytes", idx, pay.size());
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    do begin @(negedge clk_rmii); n++; end
    while ((busy !== 1'b0 || np_busy !== 1'b0) && n < limit);
    chk("idle_reached", (busy === 1'b0 && np_busy === 1'b0), 1);
  endtask

  task automatic start_chk(input string tag, input logic [7:0] b0, input bit lst);
    @(negedge clk_rmii);
    s_tdata = b0; s_tlast = lst; s_tvalid = 1'b1;
    @(posedge clk_rmii); #1;
    chk({tag, "_txen"}, tx_en, 1);
    chk({tag, "_txd"}, txd, 2'b01);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_tready"}, s_tready, 0);
    chk({tag, "_und"}, underrun, 0);
  endtask

  task automatic check_frame(input string tag, input bq_t pay, input bit pad_en, input bit use_np,
                             output logic [31:0] f);
    bq_t body, exp, got;
    int mism = 0;
    body = pay;
    if (pad_en) while (body.size() < 60) body.push_back(8'h00);
    f = ~crc_ref(body);
    repeat (7) exp.push_back(8'h55);
    exp.push_back(8'hD5);
    foreach (body[i]) exp.push_back(body[i]);
    for (int i = 0; i < 4; i++) exp.push_back(f[8*i +: 8]);
    if (use_np) got = np_last; else got = rx_last;
    chk({tag, "_len"}, got.size(), exp.size());
    if (got.size() == exp.size()) foreach (exp[i]) if (got[i] !== exp[i]) mism++;
    chk({tag, "_bytes_bad"}, mism, 0);
    chk({tag, "_en_cycles"}, use_np ? np_lcyc : rx_lcyc, 4 * exp.size());
    chk({tag, "_fcs_port"}, use_np ? np_fcs : fcs, f);
  endtask

  initial begin
    bq_t p, pb;
    logic [31:0] fexp, fprev;
    int d0;
    int lens[6] = '{1, 1514, 59, 60, 61, 0};

    repeat (3) @(posedge clk_rmii); #1;
    chk("rst_txd", txd, 0);
    chk("rst_txen", tx_en, 0);
    chk("rst_tready", s_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_und", underrun, 0);
    chk("rst_fcs", fcs, 0);
    @(negedge clk_rmii); rstn = 1'b1;
    repeat (4) @(negedge clk_rmii);

    // no padding, check value frame
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    d0 = np_done; np_go = 1'b1;
    send(p, 1'b0, -1, -1);
    @(negedge clk_rmii); s_tvalid = 1'b0; np_go = 1'b0;
    wait_idle(2000);
    check_frame("t1", p, 1'b0, 1'b1, fexp);
    chk("t1_fcs_const", np_fcs, 32'hCBF43926);
    chk("t1_en_84", np_lcyc, 84);
    chk("t1_done", np_done - d0, 1);

    // short frame padded to 60 payload bytes
    p = rand_pay(9); d0 = n_done;
    start_chk("t2_start", p[0], 1'b0);
    send(p, 1'b0, -1, -1);
    @(negedge clk_rmii); s_tvalid = 1'b0;
    wait_idle(2000);
    check_frame("t2", p, 1'b1, 1'b0, fexp);
    chk("t2_en_288", rx_lcyc, 288);
    chk("t2_done", n_done - d0, 1);

    // back-to-back with s_tvalid held high
    p = rand_pay(20); pb = rand_pay(70); d0 = n_done;
    send(p, 1'b0, -1, -1);
    send(pb, 1'b0, -1, -1);
    @(negedge clk_rmii); s_tvalid = 1'b0;
    wait_idle(3000);
    check_frame("t3b", pb, 1'b1, 1'b0, fexp);
    chk("t3_gap", last_gap, 48);
    chk("t3_busy_gap", last_bgap, 1);
    chk("t3_done", n_done - d0, 2);

    // underrun on the fifth payload byte
    fprev = fexp; p = rand_pay(100); d0 = n_done;
    send(p, 1'b0, 4, -1);
    @(negedge clk_rmii); s_tvalid = 1'b0;
    wait_idle(2000);
    chk("t4_und_sticky", underrun, 1);
    chk("t4_fcs_kept", fcs, fprev);
    chk("t4_no_done", n_done - d0, 0);
    chk("t4_en_cycles", rx_lcyc, 48);
    p = rand_pay(30); d0 = n_done;
    start_chk("t4_restart", p[0], 1'b0);
    send(p, 1'b0, -1, -1);
    @(negedge clk_rmii); s_tvalid = 1'b0;
    wait_idle(2000);
    check_frame("t4b", p, 1'b1, 1'b0, fexp);
    chk("t4b_done", n_done - d0, 1);

    // reset pulse mid-payload, then a fresh frame
    p = rand_pay(40); d0 = n_done;
    send(p, 1'b0, -1, 3);
    p = rand_pay(30);
    start_chk("t5_fresh", p[0], 1'b0);
    send(p, 1'b0, -1, -1);
    @(negedge clk_rmii); s_tvalid = 1'b0;
    wait_idle(2000);
    check_frame("t5", p, 1'b1, 1'b0, fexp);
    chk("t5_done", n_done - d0, 1);

    // random lengths with stalls outside the ready windows
    lens[5] = $urandom_range(2, 1514);
    foreach (lens[k]) begin
      p = rand_pay(lens[k]); d0 = n_done;
      send(p, 1'b1, -1, -1);
      @(negedge clk_rmii); s_tvalid = 1'b0;
      wait_idle(10000);
      check_frame($sformatf("t6_len%0d", lens[k]), p, 1'b1, 1'b0, fexp);
      chk("t6_done", n_done - d0, 1);
    end

    chk("tready_phase", tready_bad, 0);
    chk("done_timing", done_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
